// File: rtl/grid_run_ctrl.sv
// grid_run_ctrl: launch sequencer for a PE grid.
// Sequence per launch: hold every PE in reset, strobe preload, then enable
// instruction issue. The run ends when every participating PE has reported
// finish, or with an error when the optional cycle limit is reached.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no launch; all PE resets asserted
//  RESET   | all PE resets held for RST_CYCLES cycles
//  PRELOAD | masked PEs out of reset, preload strobe for PRELOAD_CYCLES
//  RUN     | instruction enable on, counting cycles, collecting finishes
//  DONE    | run completed; done pulses on the first cycle only
//  ERROR   | empty mask or timeout; error flag held until next start
module grid_run_ctrl #(
    parameter int N_PE           = 16,
    parameter int RST_CYCLES     = 4,
    parameter int PRELOAD_CYCLES = 2,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_PE-1:0]  pe_mask,
    input  logic [CNT_W-1:0] timeout_limit,
    input  logic [N_PE-1:0]  pe_finish,
    output logic [N_PE-1:0]  pe_rst,
    output logic             preload,
    output logic             inst_en,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [N_PE-1:0]  finish_seen
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESET   = 3'd1;
    localparam logic [2:0] S_PRELOAD = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    localparam int PH_W = 16;

    logic [2:0]       state_q, state_nxt;
    logic [PH_W-1:0]  phase_q, phase_nxt;
    logic [N_PE-1:0]  mask_q, mask_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [N_PE-1:0]  seen_nxt;
    logic             error_nxt;
    logic             done_nxt;

    logic [N_PE-1:0]  seen_run;
    logic             complete;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    logic [N_PE-1:0]  pe_rst_nxt;
    logic             preload_nxt;
    logic             inst_en_nxt;
    logic             busy_nxt;

    // Completion and timeout terms for the current RUN cycle; the limit is
    // compared against the count including this cycle so a limit of L means
    // at most L RUN cycles.
    always_comb begin
        seen_run    = finish_seen | (pe_finish & mask_q);
        complete    = (seen_run == mask_q);
        cnt_inc     = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
        timeout_hit = (timeout_limit != '0) && (cnt_inc == timeout_limit);
    end

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        state_nxt = state_q;
        phase_nxt = phase_q;
        mask_nxt  = mask_q;
        count_nxt = cycle_count;
        seen_nxt  = finish_seen;
        error_nxt = error;
        done_nxt  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    if (pe_mask != '0) begin
                        state_nxt = S_RESET;
                        phase_nxt = PH_W'(RST_CYCLES - 1);
                        mask_nxt  = pe_mask;
                        count_nxt = '0;
                        seen_nxt  = '0;
                        error_nxt = 1'b0;
                    end else begin
                        // Empty mask: nothing participates, keep every PE in reset.
                        state_nxt = S_ERROR;
                        mask_nxt  = '0;
                        error_nxt = 1'b1;
                    end
                end
            end
            S_RESET: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (phase_q == '0) begin
                    state_nxt = S_PRELOAD;
                    phase_nxt = PH_W'(PRELOAD_CYCLES - 1);
                end else begin
                    phase_nxt = phase_q - 1'b1;
                end
            end
            S_PRELOAD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (phase_q == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    phase_nxt = phase_q - 1'b1;
                end
            end
            S_RUN: begin
                // Abort freezes the count and finish flags as they stood.
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    count_nxt = cnt_inc;
                    seen_nxt  = seen_run;
                    if (complete) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else if (timeout_hit) begin
                        state_nxt = S_ERROR;
                        error_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output values derived from the upcoming state so every output is a flop.
    always_comb begin
        pe_rst_nxt  = ((state_nxt == S_IDLE) || (state_nxt == S_RESET)) ? '1 : ~mask_nxt;
        preload_nxt = (state_nxt == S_PRELOAD);
        inst_en_nxt = (state_nxt == S_RUN);
        busy_nxt    = (state_nxt == S_RESET) || (state_nxt == S_PRELOAD) ||
                      (state_nxt == S_RUN);
    end

    // State, counters and registered outputs; rst overrides start/abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            mask_q      <= '0;
            cycle_count <= '0;
            finish_seen <= '0;
            error       <= 1'b0;
            done        <= 1'b0;
            pe_rst      <= '1;
            preload     <= 1'b0;
            inst_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            phase_q     <= phase_nxt;
            mask_q      <= mask_nxt;
            cycle_count <= count_nxt;
            finish_seen <= seen_nxt;
            error       <= error_nxt;
            done        <= done_nxt;
            pe_rst      <= pe_rst_nxt;
            preload     <= preload_nxt;
            inst_en     <= inst_en_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_grid_run_ctrl.sv
// Directed testbench for grid_run_ctrl with default parameters
// (16 PEs, 4 reset cycles, 2 preload cycles, 32-bit counter).
module tb_grid_run_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] pe_mask;
    logic [31:0] timeout_limit;
    logic [15:0] pe_finish;
    logic [15:0] pe_rst;
    logic        preload;
    logic        inst_en;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] cycle_count;
    logic [15:0] finish_seen;

    int checks = 0;
    int errors = 0;

    grid_run_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .pe_mask       (pe_mask),
        .timeout_limit (timeout_limit),
        .pe_finish     (pe_finish),
        .pe_rst        (pe_rst),
        .preload       (preload),
        .inst_en       (inst_en),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .cycle_count   (cycle_count),
        .finish_seen   (finish_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle and advance through RESET and PRELOAD,
    // leaving the bench positioned in RUN cycle 1.
    task automatic launch_to_run(input logic [15:0] m, input logic [31:0] lim);
        pe_mask       = m;
        timeout_limit = lim;
        start         = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pe_mask = '0; timeout_limit = '0; pe_finish = '0;
        repeat (2) step();
        checks++;
        if (pe_rst !== 16'hFFFF || preload !== 1'b0 || inst_en !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0 || cycle_count !== 32'd0 || finish_seen !== 16'h0) begin
            errors++;
            $display("FAIL reset_values pe_rst=%h pre=%b ie=%b busy=%b done=%b err=%b cnt=%0d seen=%h required FFFF 0 0 0 0 0 0 0000",
                     pe_rst, preload, inst_en, busy, done, error, cycle_count, finish_seen);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_normal();
        int done_cnt;
        pe_mask = 16'h0003; timeout_limit = '0; start = 1'b1;
        step();
        start = 1'b0;
        // RESET must last exactly four cycles.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || pe_rst !== 16'hFFFF || preload !== 1'b0) begin
                errors++;
                $display("FAIL normal_reset_c%0d busy=%b pe_rst=%h pre=%b required 1 FFFF 0", i, busy, pe_rst, preload);
            end
            if (i < 3) step();
        end
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (preload !== 1'b1 || pe_rst !== 16'hFFFC || inst_en !== 1'b0) begin
                errors++;
                $display("FAIL normal_preload_c%0d pre=%b pe_rst=%h ie=%b required 1 FFFC 0", i, preload, pe_rst, inst_en);
            end
            step();
        end
        done_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (inst_en !== 1'b1 || preload !== 1'b0 || pe_rst !== 16'hFFFC) begin
                errors++;
                $display("FAIL normal_run_c%0d ie=%b pre=%b pe_rst=%h required 1 0 FFFC", k, inst_en, preload, pe_rst);
            end
            pe_finish = {14'd0, (k >= 10), (k >= 5)};
            step();
            if (done === 1'b1) done_cnt++;
        end
        pe_finish = '0;
        checks++;
        if (done !== 1'b1 || cycle_count !== 32'd10 || busy !== 1'b0 || inst_en !== 1'b0 ||
            finish_seen !== 16'h0003 || error !== 1'b0) begin
            errors++;
            $display("FAIL normal_done done=%b cnt=%0d busy=%b ie=%b seen=%h err=%b required 1 10 0 0 0003 0",
                     done, cycle_count, busy, inst_en, finish_seen, error);
        end
        step();
        if (done === 1'b1) done_cnt++;
        checks++;
        if (done_cnt !== 1 || pe_rst !== 16'hFFFC || cycle_count !== 32'd10) begin
            errors++;
            $display("FAIL normal_done_once pulses=%0d pe_rst=%h cnt=%0d required 1 FFFC 10", done_cnt, pe_rst, cycle_count);
        end
    endtask

    task automatic test_pulsed();
        logic [15:0] exp_seen;
        launch_to_run(16'hFFFF, 32'd0);
        checks++;
        if (pe_rst !== 16'h0000 || inst_en !== 1'b1) begin
            errors++;
            $display("FAIL pulsed_run_entry pe_rst=%h ie=%b required 0000 1", pe_rst, inst_en);
        end
        exp_seen = '0;
        for (int k = 0; k < 32; k++) begin
            pe_finish = (k % 2 == 1) ? (16'h0001 << (k / 2)) : 16'h0000;
            if (k % 2 == 1) exp_seen = exp_seen | (16'h0001 << (k / 2));
            step();
            pe_finish = '0;
            checks++;
            if (finish_seen !== exp_seen || done !== (k == 31)) begin
                errors++;
                $display("FAIL pulsed_c%0d seen=%h done=%b required %h %b", k, finish_seen, done, exp_seen, (k == 31));
            end
        end
        checks++;
        if (cycle_count !== 32'd32 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulsed_count cnt=%0d busy=%b required 32 0", cycle_count, busy);
        end
    endtask

    task automatic test_timeout();
        int bad_done;
        launch_to_run(16'h0001, 32'd20);
        bad_done = 0;
        for (int k = 1; k <= 20; k++) begin
            checks++;
            if (inst_en !== 1'b1 || error !== 1'b0) begin
                errors++;
                $display("FAIL timeout_run_c%0d ie=%b err=%b required 1 0", k, inst_en, error);
            end
            step();
            if (done === 1'b1) bad_done++;
        end
        step();
        if (done === 1'b1) bad_done++;
        checks++;
        if (error !== 1'b1 || inst_en !== 1'b0 || cycle_count !== 32'd20 || busy !== 1'b0 ||
            bad_done !== 0 || pe_rst !== 16'hFFFE) begin
            errors++;
            $display("FAIL timeout_error err=%b ie=%b cnt=%0d busy=%b done_pulses=%0d pe_rst=%h required 1 0 20 0 0 FFFE",
                     error, inst_en, cycle_count, busy, bad_done, pe_rst);
        end
    endtask

    task automatic test_abort();
        pe_mask = 16'h0003; timeout_limit = '0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        checks++;
        if (preload !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_preload pre=%b err=%b required 1 0", preload, error);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || pe_rst !== 16'hFFFF || done !== 1'b0 || preload !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy=%b pe_rst=%h done=%b pre=%b err=%b required 0 FFFF 0 0 0",
                     busy, pe_rst, done, preload, error);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle busy=%b done=%b required 0 0", busy, done);
        end
        launch_to_run(16'h0003, 32'd0);
        pe_finish = 16'h0003;
        step();
        pe_finish = '0;
        checks++;
        if (done !== 1'b1 || cycle_count !== 32'd1 || finish_seen !== 16'h0003) begin
            errors++;
            $display("FAIL abort_rerun done=%b cnt=%0d seen=%h required 1 1 0003", done, cycle_count, finish_seen);
        end
    endtask

    task automatic test_edges();
        // Empty mask from DONE.
        pe_mask = 16'h0000; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || pe_rst !== 16'hFFFF) begin
            errors++;
            $display("FAIL edge_empty_mask err=%b busy=%b pe_rst=%h required 1 0 FFFF", error, busy, pe_rst);
        end
        // Start while running is ignored; mask stays as launched.
        launch_to_run(16'h0001, 32'd0);
        pe_mask = 16'hFFFF; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || inst_en !== 1'b1 || pe_rst !== 16'hFFFE || cycle_count !== 32'd1 || error !== 1'b0) begin
            errors++;
            $display("FAIL edge_start_in_run busy=%b ie=%b pe_rst=%h cnt=%0d err=%b required 1 1 FFFE 1 0",
                     busy, inst_en, pe_rst, cycle_count, error);
        end
        pe_finish = 16'h0001;
        step();
        pe_finish = '0;
        checks++;
        if (done !== 1'b1 || cycle_count !== 32'd2) begin
            errors++;
            $display("FAIL edge_run_after_start done=%b cnt=%0d required 1 2", done, cycle_count);
        end
        // Finish on the timeout cycle completes.
        launch_to_run(16'h0001, 32'd3);
        repeat (2) step();
        pe_finish = 16'h0001;
        step();
        pe_finish = '0;
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cycle_count !== 32'd3) begin
            errors++;
            $display("FAIL edge_finish_on_timeout done=%b err=%b cnt=%0d required 1 0 3", done, error, cycle_count);
        end
        // Synchronous reset in RUN wins over abort and start.
        launch_to_run(16'h0003, 32'd0);
        pe_finish = 16'h0001;
        repeat (2) step();
        pe_finish = '0;
        checks++;
        if (finish_seen !== 16'h0001 || cycle_count !== 32'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL edge_pre_rst seen=%h cnt=%0d busy=%b required 0001 2 1", finish_seen, cycle_count, busy);
        end
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        checks++;
        if (pe_rst !== 16'hFFFF || preload !== 1'b0 || inst_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            error !== 1'b0 || cycle_count !== 32'd0 || finish_seen !== 16'h0) begin
            errors++;
            $display("FAIL edge_rst_in_run pe_rst=%h pre=%b ie=%b busy=%b done=%b err=%b cnt=%0d seen=%h required FFFF 0 0 0 0 0 0 0000",
                     pe_rst, preload, inst_en, busy, done, error, cycle_count, finish_seen);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_pulsed();
        test_timeout();
        test_abort();
        test_edges();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
